// File: rtl/led_trail_pwm_if.sv
// LED drive bus for the afterglow PWM stage.
//
// Groups the scanner-facing pattern inputs and the LED-facing outputs so the
// producer (scanner or bench) and the PWM stage share one connection.
//   en       : channel enable, low forces all LEDs dark and clears levels
//   led_in   : on/off pattern from the scanner, one bit per LED
//   LEDout   : registered PWM drive, 1 = lit
//   pwm_wrap : registered one-cycle pulse at the start of each PWM period
// Modports:
//   master : drives en/led_in, observes LEDout/pwm_wrap
//   slave  : the PWM stage itself
interface led_trail_pwm_if #(
    parameter int N_LEDS = 10
);
    logic              en;
    logic [N_LEDS-1:0] led_in;
    logic [N_LEDS-1:0] LEDout;
    logic              pwm_wrap;

    modport master (
        output en,
        output led_in,
        input  LEDout,
        input  pwm_wrap
    );

    modport slave (
        input  en,
        input  led_in,
        output LEDout,
        output pwm_wrap
    );
endinterface

// File: rtl/led_trail_pwm.sv
// Afterglow PWM driver for the scanner LEDs.
//
// Each channel jumps to full brightness while its pattern bit is high and,
// once the bit drops, fades linearly by DECAY_STEP every DECAY_DIV cycles
// until dark. Brightness is rendered by comparing each channel's level with
// a shared free-running PWM counter, so all fades stay phase-aligned.
//
// Ports:
//   clkin : system clock, all state on posedge
//   rst   : asynchronous, active-high reset
//   bus   : led_trail_pwm_if slave (en, led_in in; LEDout, pwm_wrap out)
module led_trail_pwm #(
    parameter int N_LEDS     = 10,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 250000,
    parameter int DECAY_STEP = 16
) (
    input  logic             clkin,
    input  logic             rst,
    led_trail_pwm_if.slave   bus
);
    localparam int                  DCNT_W    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);
    localparam logic [DCNT_W-1:0]   DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

    // One fade step, saturating at dark instead of wrapping to bright.
    function automatic logic [PWM_BITS-1:0] decay_sat(input logic [PWM_BITS-1:0] lvl);
        return (lvl > STEP) ? (lvl - STEP) : '0;
    endfunction

    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic [DCNT_W-1:0]   decay_cnt_q, decay_cnt_d;
    logic [PWM_BITS-1:0] level_q [N_LEDS];
    logic [PWM_BITS-1:0] level_d [N_LEDS];
    logic [N_LEDS-1:0]   led_out_q,   led_out_d;
    logic                pwm_wrap_q,  pwm_wrap_d;
    logic                decay_tick;

    assign decay_tick = (decay_cnt_q == DCNT_LAST);

    always_comb begin
        // Both counters free-run independent of en.
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        decay_cnt_d = decay_tick ? '0 : (decay_cnt_q + 1'b1);
        pwm_wrap_d  = (pwm_cnt_q == LVL_MAX);

        level_d   = level_q;
        led_out_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            // A lit input beats a coincident fade step, so a held bit
            // never dims.
            if (!bus.en) begin
                level_d[i] = '0;
            end else if (bus.led_in[i]) begin
                level_d[i] = LVL_MAX;
            end else if (decay_tick) begin
                level_d[i] = decay_sat(level_q[i]);
            end

            // Strict compare: level 0 never lights, level MAX misses the
            // single cycle where the counter equals MAX.
            led_out_d[i] = bus.en & (level_q[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            pwm_cnt_q   <= '0;
            decay_cnt_q <= '0;
            led_out_q   <= '0;
            pwm_wrap_q  <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            decay_cnt_q <= decay_cnt_d;
            led_out_q   <= led_out_d;
            pwm_wrap_q  <= pwm_wrap_d;
            for (int i = 0; i < N_LEDS; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign bus.LEDout   = led_out_q;
    assign bus.pwm_wrap = pwm_wrap_q;
endmodule
